// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_pkg
//  Description : Shared state encoding and width helpers for the sequential
//                integer square-root unit (isqrt_seq / isqrt_step).
//  Revision    : 1.0 - initial radix-2 restoring implementation
// ============================================================================
package isqrt_pkg;

  // Controller states; the encoding is fixed so it can be read from a probe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Radicand width used when an instance does not override it.
  localparam int C_W_DEFAULT = 16;

  // Root width: one root bit per pair of radicand bits.
  function automatic int q_width(input int w);
    return w / 2;
  endfunction

  // Published remainder width: the floored remainder never exceeds 2*Q.
  function automatic int r_width(input int w);
    return (w / 2) + 1;
  endfunction

  // Working remainder width: two extra bits absorb the shifted-in digit pair
  // before the trial subtraction of the last iteration.
  function automatic int rem_width(input int w);
    return (w / 2) + 2;
  endfunction

  // Iteration counter width: holds W/2-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    int n;
    n = $clog2(w / 2);
    return (n < 1) ? 1 : n;
  endfunction

endpackage : isqrt_pkg
`default_nettype wire

// File: rtl/isqrt_step.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_step
//  Description : One combinational iteration of the radix-2 restoring square
//                root: bring down two radicand bits, try subtracting
//                (4*root+1), keep the result and set the new root bit when it
//                does not go negative.
//  Revision    : 1.0 - initial radix-2 restoring implementation
// ============================================================================
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int W = C_W_DEFAULT
) (
  input  logic [rem_width(W)-1:0] i_rem,
  input  logic [q_width(W)-1:0]   i_root,
  input  logic [1:0]              i_bits,
  output logic [rem_width(W)-1:0] o_rem,
  output logic [q_width(W)-1:0]   o_root
);

  localparam int c_qw = q_width(W);
  localparam int c_rw = rem_width(W);

  logic [c_rw-1:0] w_rem_sh;
  logic [c_rw-1:0] w_trial;
  logic            w_fits;

  // Trial subtraction for a single root digit.
  always_comb begin
    // The remainder entering a step is at most 2*root, so the bits shifted
    // out at the top are always zero.
    w_rem_sh = (i_rem << 2) | {{(c_rw-2){1'b0}}, i_bits};
    w_trial  = {i_root, 2'b01};
    w_fits   = (w_rem_sh >= w_trial);
    o_rem    = w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
    o_root   = (i_root << 1) | {{(c_qw-1){1'b0}}, w_fits};
  end

endmodule : isqrt_step
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq
//  Description : Sequential integer square root. Accepts a W-bit radicand in
//                IDLE, resolves one root bit per clock for W/2 clocks, then
//                publishes Q (floored or rounded root) and R (floored
//                remainder) with a one-cycle ack.
//  Revision    : 1.0 - initial radix-2 restoring implementation
// ============================================================================
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int W     = C_W_DEFAULT,
  parameter int ROUND = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [W-1:0]          A,
  output logic                  ready,
  output logic                  ack,
  output logic [q_width(W)-1:0] Q,
  output logic [r_width(W)-1:0] R
);

  localparam int c_qw = q_width(W);
  localparam int c_pw = r_width(W);
  localparam int c_rw = rem_width(W);
  localparam int c_cw = cnt_width(W);
  localparam logic [c_cw-1:0] c_cnt_init = c_cw'(c_qw - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_load;
  logic            w_finish;

  logic [W-1:0]    r_rad;
  logic [c_rw-1:0] r_rem;
  logic [c_qw-1:0] r_root;
  logic [c_cw-1:0] r_cnt;
  logic            r_ready;
  logic            r_ack;
  logic [c_qw-1:0] r_q;
  logic [c_pw-1:0] r_r;

  logic [c_rw-1:0] w_rem_nxt;
  logic [c_qw-1:0] w_root_nxt;
  logic [c_qw-1:0] w_q_final;

  // Single digit-recurrence step fed by the top two radicand bits.
  isqrt_step #(
    .W (W)
  ) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_rad[W-1:W-2]),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  // Select the published root; R always stays the floored remainder.
  generate
    if (ROUND != 0) begin : g_round
      logic w_round_up;
      logic w_root_max;

      // Round up when A exceeds root^2 + root, i.e. rem > root, unless the
      // root is already all ones.
      always_comb begin
        w_round_up = (w_rem_nxt > {2'b00, w_root_nxt});
        w_root_max = &w_root_nxt;
        w_q_final  = (w_round_up && !w_root_max) ? (w_root_nxt + 1'b1)
                                                 : w_root_nxt;
      end
    end else begin : g_floor
      assign w_q_final = w_root_nxt;
    end
  endgenerate

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the load/finish strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CALC;
          w_load      = 1'b1;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
          w_finish    = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Iteration datapath: radicand shifter, partial root/remainder, counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_rad  <= A;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= c_cnt_init;
    end else if (r_state == CALC) begin
      r_rad  <= r_rad << 2;
      r_rem  <= w_rem_nxt;
      r_root <= w_root_nxt;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Registered handshake and result outputs; results hold until the next
  // completion.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ready <= 1'b1;
      r_ack   <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_ack   <= w_finish;
      if (w_finish) begin
        r_q <= w_q_final;
        r_r <= w_rem_nxt[c_pw-1:0];
      end
    end
  end

  assign ready = r_ready;
  assign ack   = r_ack;
  assign Q     = r_q;
  assign R     = r_r;

endmodule : isqrt_seq
`default_nettype wire

// File: tb/tb_isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_seq
//  Description : Bench for isqrt_seq. Three instances (W=8 floor, W=16 floor,
//                W=16 round) are tracked by a transaction-level model of the
//                handshake timeline and the arithmetic result.
//  Revision    : 1.0 - initial bench
// ============================================================================
module tb_isqrt_seq;

  logic        Clk;
  logic        Rst;
  logic        s8;
  logic [7:0]  a8;
  logic        s16;
  logic [15:0] a16;

  logic        rdy0, ack0;
  logic [3:0]  q0;
  logic [4:0]  r0;
  logic        rdy1, ack1;
  logic [7:0]  q1;
  logic [8:0]  r1;
  logic        rdy2, ack2;
  logic [7:0]  q2;
  logic [8:0]  r2;

  int n_checks = 0;
  int n_err    = 0;

  isqrt_seq #(.W(8), .ROUND(0)) dut8 (
    .Clk(Clk), .Rst(Rst), .start(s8), .A(a8),
    .ready(rdy0), .ack(ack0), .Q(q0), .R(r0)
  );

  isqrt_seq #(.W(16), .ROUND(0)) dut16f (
    .Clk(Clk), .Rst(Rst), .start(s16), .A(a16),
    .ready(rdy1), .ack(ack1), .Q(q1), .R(r1)
  );

  isqrt_seq #(.W(16), .ROUND(1)) dut16r (
    .Clk(Clk), .Rst(Rst), .start(s16), .A(a16),
    .ready(rdy2), .ack(ack2), .Q(q2), .R(r2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: largest f with f*f <= a; nearest root saturating.
  function automatic void ref_sqrt(input longint a, input int hw, input bit rnd,
                                   output int q, output int r);
    longint f;
    f = 0;
    while ((f + 1) * (f + 1) <= a) f++;
    r = int'(a - f * f);
    q = int'(f);
    if (rnd && (4 * a > (2 * f + 1) * (2 * f + 1)) && (f < (64'd1 << hw) - 1))
      q = int'(f + 1);
  endfunction

  // Transaction model per instance: 0 = W8 floor, 1 = W16 floor, 2 = W16 round.
  int     c_hw [3] = '{4, 8, 8};
  bit     c_rnd[3] = '{1'b0, 1'b0, 1'b1};
  int     m_left [3];
  bit     m_ready[3];
  bit     m_ack  [3];
  longint m_a    [3];
  int     m_q    [3];
  int     m_r    [3];

  always @(posedge Clk or posedge Rst) begin : p_model
    bit     st;
    longint av;
    if (Rst) begin
      for (int i = 0; i < 3; i++) begin
        m_left[i] = 0; m_ready[i] = 1'b1; m_ack[i] = 1'b0;
        m_a[i] = 0; m_q[i] = 0; m_r[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        st = (i == 0) ? s8 : s16;
        av = (i == 0) ? longint'(a8) : longint'(a16);
        if (m_left[i] > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_ack[i] = 1'b1;
            ref_sqrt(m_a[i], c_hw[i], c_rnd[i], m_q[i], m_r[i]);
          end
        end else if (m_ack[i]) begin
          m_ack[i]   = 1'b0;
          m_ready[i] = 1'b1;
        end else if (m_ready[i] && st) begin
          m_ready[i] = 1'b0;
          m_left[i]  = c_hw[i];
          m_a[i]     = av;
        end
      end
    end
  end

  // Every falling edge out of reset, all outputs must follow the model.
  always @(negedge Clk) begin
    if (!Rst) begin
      chk("w8_ready",   rdy0, m_ready[0]);
      chk("w8_ack",     ack0, m_ack[0]);
      chk("w8_q",       q0,   m_q[0]);
      chk("w8_r",       r0,   m_r[0]);
      chk("w16f_ready", rdy1, m_ready[1]);
      chk("w16f_ack",   ack1, m_ack[1]);
      chk("w16f_q",     q1,   m_q[1]);
      chk("w16f_r",     r1,   m_r[1]);
      chk("w16r_ready", rdy2, m_ready[2]);
      chk("w16r_ack",   ack2, m_ack[2]);
      chk("w16r_q",     q2,   m_q[2]);
      chk("w16r_r",     r2,   m_r[2]);
    end
  end

  // One W=8 operation; lat counts edges from acceptance to ack.
  task automatic run8(input logic [7:0] a, output int lat);
    int k;
    k = 0;
    @(negedge Clk);
    while (!rdy0 && k < 20) begin @(negedge Clk); k++; end
    chk("w8_ready_wait", rdy0, 1'b1);
    s8 = 1'b1; a8 = a;
    @(negedge Clk);
    s8 = 1'b0; a8 = 8'($urandom);
    lat = 0;
    while (!ack0 && lat < 20) begin @(negedge Clk); lat++; end
    chk("w8_ack_wait", ack0, 1'b1);
  endtask

  // One W=16 operation on both 16-bit instances.
  task automatic run16(input logic [15:0] a, output int lat);
    int k;
    k = 0;
    @(negedge Clk);
    while (!rdy1 && k < 40) begin @(negedge Clk); k++; end
    chk("w16_ready_wait", rdy1, 1'b1);
    s16 = 1'b1; a16 = a;
    @(negedge Clk);
    s16 = 1'b0; a16 = 16'($urandom);
    lat = 0;
    while (!ack1 && lat < 40) begin @(negedge Clk); lat++; end
    chk("w16_ack_wait", ack1, 1'b1);
  endtask

  initial begin : p_stim
    int lat;
    int acks;
    int k;
    Rst = 1'b1; s8 = 1'b0; a8 = '0; s16 = 1'b0; a16 = '0;
    repeat (3) @(negedge Clk);
    chk("rst_ready", rdy1, 1'b1);
    chk("rst_ack",   ack1, 1'b0);
    chk("rst_q",     q1,   8'd0);
    chk("rst_r",     r1,   9'd0);
    Rst = 1'b0;

    // W=8: 81 -> 9 rem 0, four edges from accept to ack.
    run8(8'd81, lat);
    chk("w8_lat_81", lat, 4);
    chk("w8_q_81", q0, 4'd9);
    chk("w8_r_81", r0, 5'd0);

    // W=8 exhaustive sweep, checked by the compare process.
    for (int a = 0; a < 256; a++) begin
      run8(8'(a), lat);
      chk("w8_lat", lat, 4);
    end

    // W=16 pinned values.
    run16(16'd80, lat);
    chk("w16_lat_80", lat, 8);
    chk("f_q_80", q1, 8'd8);   chk("f_r_80", r1, 9'd16);
    chk("r_q_80", q2, 8'd9);   chk("r_r_80", r2, 9'd16);
    run16(16'd0, lat);
    chk("f_q_0", q1, 8'd0);    chk("f_r_0", r1, 9'd0);
    run16(16'd65535, lat);
    chk("f_q_max", q1, 8'd255); chk("f_r_max", r1, 9'd510);
    chk("r_q_max", q2, 8'd255); chk("r_r_max", r2, 9'd510);
    run16(16'd72, lat);
    chk("f_q_72", q1, 8'd8);   chk("f_r_72", r1, 9'd8);
    chk("r_q_72", q2, 8'd8);   chk("r_r_72", r2, 9'd8);

    // start held high: one result every 10 clocks, each Q=10.
    k = 0;
    @(negedge Clk);
    while (!rdy1 && k < 40) begin @(negedge Clk); k++; end
    s16 = 1'b1; a16 = 16'd100;
    acks = 0;
    repeat (30) begin
      @(negedge Clk);
      if (ack1) begin
        acks++;
        chk("held_q_100", q1, 8'd10);
      end
    end
    s16 = 1'b0;
    chk("held_ack_count", acks, 3);

    // A changed and start re-pulsed during CALC: single result for 49.
    k = 0;
    @(negedge Clk);
    while (!rdy1 && k < 40) begin @(negedge Clk); k++; end
    s16 = 1'b1; a16 = 16'd49;
    @(negedge Clk);
    s16 = 1'b0; a16 = 16'd200;
    repeat (2) @(negedge Clk);
    s16 = 1'b1;
    @(negedge Clk);
    s16 = 1'b0;
    acks = 0;
    repeat (12) begin
      @(negedge Clk);
      if (ack1) begin
        acks++;
        chk("midcalc_q", q1, 8'd7);
        chk("midcalc_r", r1, 9'd0);
      end
    end
    chk("midcalc_ack_count", acks, 1);

    // Random radicands with random idle gaps.
    for (int n = 0; n < 300; n++) begin
      run16(16'($urandom), lat);
      chk("w16_lat", lat, 8);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end

    // Asynchronous reset in the middle of CALC.
    k = 0;
    @(negedge Clk);
    while (!rdy1 && k < 40) begin @(negedge Clk); k++; end
    s16 = 1'b1; a16 = 16'd1000;
    @(negedge Clk);
    s16 = 1'b0;
    repeat (2) @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    chk("arst_ready", rdy1, 1'b1);
    chk("arst_ack",   ack1, 1'b0);
    chk("arst_q",     q1,   8'd0);
    chk("arst_r",     r1,   9'd0);
    chk("arst_q_rnd", q2,   8'd0);
    @(posedge Clk);
    #2 Rst = 1'b0;
    run16(16'd144, lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_q", q1, 8'd12);
    chk("post_rst_r", r1, 9'd0);

    repeat (3) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_isqrt_seq
`default_nettype wire
